wb_timer_slave: RTL and testbench
=================================

# wb_timer_slave

Wishbone B3 classic-cycle slave providing a 32-bit down-counting timer with prescaler, auto-reload and interrupt. It is the responder on the system's 32-bit Wishbone master port (wb_adr_o/wb_dat_o/wb_sel_o/wb_cyc_o/wb_stb_o/wb_we_o driven by the soft-core, wb_ack_i/wb_err_i/wb_rty_i/wb_dat_i returned), and gives software a hardware timer in the fabric outside the Qsys system.

## Interface
- PRESCALE_W, 16, width of prescaler register and counter (1..32)
- RESET_LOAD, 32'h0000_0000, reset value of LOAD register

- wb_clk_i  in  1  single clock; all logic on rising edge
- wb_rst_i  in  1  synchronous, active-high reset
- wb_adr_i  in  32  byte address; only [4:2] decoded, [31:5] and [1:0] ignored
- wb_dat_i  in  32  write data
- wb_dat_o  out  32  read data, valid while wb_ack_o=1
- wb_sel_i  in  4  byte-lane enables, sel[n] covers dat[8n+7:8n]
- wb_cyc_i  in  1  bus cycle
- wb_stb_i  in  1  strobe
- wb_we_i  in  1  1=write, 0=read
- wb_ack_o  out  1  normal termination
- wb_err_o  out  1  error termination (unmapped offset)
- wb_rty_o  out  1  tied 0
- irq_o  out  1  level interrupt, registered

## Operation
- Register map (offset = adr[4:2]×4):
  - 0x00 CTRL RW: [0] EN, [1] AUTO_RELOAD, [2] IRQ_EN, others read 0
  - 0x04 LOAD RW: 32-bit reload value
  - 0x08 COUNT RW: read = current count; write = load counter directly
  - 0x0C PRESCALE RW: [PRESCALE_W-1:0], upper bits read 0
  - 0x10 STATUS: [0] EXPIRED, write-1-to-clear (sel[0] required)
  - 0x14..0x1C: unmapped → wb_err_o instead of ack; writes ignored, dat_o=0
- Writes honour wb_sel_i per byte; sel=0000 write completes with ack, no state change.
- Prescaler: when EN=1, pcnt decrements each cycle; at pcnt==0 emits one-cycle tick and reloads PRESCALE. PRESCALE=0 → tick every cycle. EN 0→1 write reloads pcnt from PRESCALE. EN=0 freezes pcnt and COUNT.
- On tick: COUNT≠0 → COUNT−1. COUNT==0 → EXPIRED←1; AUTO_RELOAD=1: COUNT←LOAD; else EN←0, COUNT stays 0.
- irq_o = registered (EXPIRED & IRQ_EN).
- Simultaneous events:
  - bus write to COUNT and tick same cycle: write wins
  - EXPIRED W1C and new expiry same cycle: set wins
  - bus write of EN=1 and one-shot auto-clear same cycle: write wins
- Reset mid-transaction: ack/err drop next edge; master must restart the cycle.

## Timing
- Reset values: wb_ack_o=0, wb_err_o=0, wb_rty_o=0, wb_dat_o=0, irq_o=0, CTRL=0, COUNT=0, PRESCALE=0, pcnt=0, EXPIRED=0, LOAD=RESET_LOAD.
- Handshake: request = cyc&stb&!ack&!err at edge N → ack (or err) high for exactly one cycle N+1, then low for ≥1 cycle; max one transfer per 2 cycles. No wait states beyond this.
- Write takes effect at edge N (visible to read issued next transfer). Read data sampled at edge N, registered to wb_dat_o with ack.
- stb dropped before ack: no ack generated next cycle for a new request; in-flight ack still completes.
- Tick→COUNT update: same edge as tick. EXPIRED set on expiring tick edge; irq_o one cycle later.

## Structure
- Package wb_timer_pkg: register offset constants (CTRL..STATUS), CTRL bit indices, ADR_DECODE_LSB/MSB.
- Sub-module wb_timer_core: prescaler, counter, EXPIRED/one-shot logic; inputs are decoded write strobes + data, outputs COUNT/EXPIRED/EN_clear. Top wb_timer_slave holds bus FSM (IDLE/ACK), decode, byte merge, read mux.

## Test plan
- Reset, read all 5 registers → CTRL/COUNT/PRESCALE/STATUS=0, LOAD=RESET_LOAD; each ack exactly one cycle, N+1.
- Write LOAD=0x12345678 sel=0101, read back → 0x00340078; access to 0x18 → err one cycle, no ack, no state change.
- PRESCALE=3, COUNT=2, CTRL=0x7 (EN,AUTO,IRQ) → COUNT 2,1,0 every 4 cycles, then EXPIRED=1, COUNT=LOAD, irq_o one cycle after.
- One-shot: PRESCALE=0, COUNT=1, CTRL=0x1 → expiry after 2 cycles, EN reads 0, COUNT holds 0, irq_o stays 0 (IRQ_EN=0).
- W1C STATUS=1 on the same cycle as a new expiry → EXPIRED stays 1; COUNT write coincident with tick → written value read back.
- Assert wb_rst_i during ack cycle → ack 0 next edge, all registers at reset values.

Source files
------------

// File: rtl/wb_timer_pkg.sv
// Shared constants for the Wishbone timer slave.
// Register offsets, CTRL bit positions, address decode range, bus FSM states.
package wb_timer_pkg;

   localparam int ADR_DECODE_LSB = 2;
   localparam int ADR_DECODE_MSB = 4;

   localparam logic [2:0] OFF_CTRL     = 3'd0;
   localparam logic [2:0] OFF_LOAD     = 3'd1;
   localparam logic [2:0] OFF_COUNT    = 3'd2;
   localparam logic [2:0] OFF_PRESCALE = 3'd3;
   localparam logic [2:0] OFF_STATUS   = 3'd4;

   localparam int CTRL_EN     = 0;
   localparam int CTRL_AUTO   = 1;
   localparam int CTRL_IRQ_EN = 2;
   localparam int CTRL_W      = 3;

   typedef enum logic {
      BUS_IDLE,
      BUS_ACK
   } bus_state_e;

   // Replace the byte lanes of old_v selected by sel with new_v.
   function automatic logic [31:0] byte_merge(
      input logic [31:0] old_v,
      input logic [31:0] new_v,
      input logic [3:0]  sel
   );
      logic [31:0] r;
      r = old_v;
      for (int i = 0; i < 4; i++) begin
         if (sel[i]) r[8*i +: 8] = new_v[8*i +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/wb_timer_slave_if.sv
// Wishbone B3 classic bus bundle between the soft-core master and the timer.
// master drives adr/dat_w/sel/cyc/stb/we; slave returns dat_r/ack/err/rty.
interface wb_timer_slave_if;

   logic [31:0] wb_adr;
   logic [31:0] wb_dat_w;
   logic [31:0] wb_dat_r;
   logic [3:0]  wb_sel;
   logic        wb_cyc;
   logic        wb_stb;
   logic        wb_we;
   logic        wb_ack;
   logic        wb_err;
   logic        wb_rty;

   modport master (
      output wb_adr, wb_dat_w, wb_sel, wb_cyc, wb_stb, wb_we,
      input  wb_dat_r, wb_ack, wb_err, wb_rty
   );

   modport slave (
      input  wb_adr, wb_dat_w, wb_sel, wb_cyc, wb_stb, wb_we,
      output wb_dat_r, wb_ack, wb_err, wb_rty
   );

endinterface

// File: rtl/wb_timer_core.sv
// Prescaler, 32-bit down counter and EXPIRED flag of the timer.
// In: clk/rst, EN/AUTO, EN rise, PRESCALE, LOAD, COUNT write, W1C. Out: COUNT, EXPIRED, EN clear.
module wb_timer_core #(
   parameter int PRESCALE_W = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  en_i,
   input  logic                  auto_i,
   input  logic                  en_rise_i,
   input  logic [PRESCALE_W-1:0] prescale_i,
   input  logic [31:0]           load_i,
   input  logic                  count_we_i,
   input  logic [31:0]           count_wdata_i,
   input  logic                  status_clr_i,
   output logic [31:0]           count_o,
   output logic                  expired_o,
   output logic                  en_clr_o
);

   logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;
   logic [31:0]           count_q, count_d;
   logic                  expired_q, expired_d;
   logic                  tick;
   logic                  expire;

   assign tick   = en_i & (pcnt_q == '0);
   assign expire = tick & (count_q == 32'd0);

   always_comb begin
      pcnt_d    = pcnt_q;
      count_d   = count_q;
      expired_d = expired_q;

      if (en_rise_i || tick) begin
         pcnt_d = prescale_i;
      end else if (en_i) begin
         pcnt_d = pcnt_q - 1'b1;
      end

      // A bus write to COUNT overrides the tick in the same cycle.
      if (count_we_i) begin
         count_d = count_wdata_i;
      end else if (tick) begin
         if (count_q != 32'd0) count_d = count_q - 32'd1;
         else if (auto_i)      count_d = load_i;
      end

      // A new expiry beats a simultaneous write-1-to-clear.
      if (expire)            expired_d = 1'b1;
      else if (status_clr_i) expired_d = 1'b0;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pcnt_q    <= '0;
         count_q   <= '0;
         expired_q <= 1'b0;
      end else begin
         pcnt_q    <= pcnt_d;
         count_q   <= count_d;
         expired_q <= expired_d;
      end
   end

   assign count_o   = count_q;
   assign expired_o = expired_q;
   assign en_clr_o  = expire & ~auto_i;

endmodule

// File: rtl/wb_timer_slave.sv
// Wishbone classic slave wrapping the down-counting timer: decode, FSM, registers.
// Ports: wb_clk_i, wb_rst_i (sync, high), wb (slave bus bundle), irq_o (level irq).
module wb_timer_slave
   import wb_timer_pkg::*;
#(
   parameter int          PRESCALE_W = 16,
   parameter logic [31:0] RESET_LOAD = 32'h0000_0000
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_i,
   wb_timer_slave_if.slave  wb,
   output logic             irq_o
);

   bus_state_e            state_q, state_d;
   logic                  ack_q, ack_d;
   logic                  err_q, err_d;
   logic [31:0]           dat_q, dat_d;
   logic                  irq_q, irq_d;
   logic [CTRL_W-1:0]     ctrl_q, ctrl_d;
   logic [31:0]           load_q, load_d;
   logic [PRESCALE_W-1:0] prescale_q, prescale_d;

   logic [2:0]  off;
   logic        req;
   logic        mapped;
   logic        wr;
   logic        ctrl_we, load_we, count_we, ps_we;
   logic        status_clr;
   logic        en_rise;
   logic [31:0] count;
   logic [31:0] count_wdata;
   logic        expired;
   logic        en_clr;
   logic [31:0] rdata;
   logic        unused_adr;

   assign off    = wb.wb_adr[ADR_DECODE_MSB:ADR_DECODE_LSB];
   assign mapped = (off <= OFF_STATUS);
   assign req    = wb.wb_cyc & wb.wb_stb & (state_q == BUS_IDLE);
   // A write with no byte lanes still acks but must not disturb the timer.
   assign wr     = req & wb.wb_we & mapped & (|wb.wb_sel);

   assign ctrl_we    = wr & (off == OFF_CTRL) & wb.wb_sel[0];
   assign load_we    = wr & (off == OFF_LOAD);
   assign count_we   = wr & (off == OFF_COUNT);
   assign ps_we      = wr & (off == OFF_PRESCALE);
   assign status_clr = wr & (off == OFF_STATUS)
                       & wb.wb_sel[0] & wb.wb_dat_w[0];
   assign en_rise    = ctrl_we & wb.wb_dat_w[CTRL_EN] & ~ctrl_q[CTRL_EN];

   assign count_wdata = byte_merge(count, wb.wb_dat_w, wb.wb_sel);

   assign unused_adr = ^{wb.wb_adr[31:ADR_DECODE_MSB+1],
                         wb.wb_adr[ADR_DECODE_LSB-1:0]};

   wb_timer_core #(
      .PRESCALE_W (PRESCALE_W)
   ) u_core (
      .clk_i         (wb_clk_i),
      .rst_i         (wb_rst_i),
      .en_i          (ctrl_q[CTRL_EN]),
      .auto_i        (ctrl_q[CTRL_AUTO]),
      .en_rise_i     (en_rise),
      .prescale_i    (prescale_q),
      .load_i        (load_q),
      .count_we_i    (count_we),
      .count_wdata_i (count_wdata),
      .status_clr_i  (status_clr),
      .count_o       (count),
      .expired_o     (expired),
      .en_clr_o      (en_clr)
   );

   always_comb begin
      ctrl_d     = ctrl_q;
      load_d     = load_q;
      prescale_d = prescale_q;
      // One-shot clear first so a same-cycle EN write wins.
      if (en_clr)  ctrl_d[CTRL_EN] = 1'b0;
      if (ctrl_we) ctrl_d = wb.wb_dat_w[CTRL_W-1:0];
      if (load_we) load_d = byte_merge(load_q, wb.wb_dat_w, wb.wb_sel);
      if (ps_we) begin
         for (int i = 0; i < PRESCALE_W; i++) begin
            if (wb.wb_sel[i/8]) prescale_d[i] = wb.wb_dat_w[i];
         end
      end
   end

   always_comb begin
      rdata = '0;
      unique case (off)
         OFF_CTRL:     rdata = {{(32-CTRL_W){1'b0}}, ctrl_q};
         OFF_LOAD:     rdata = load_q;
         OFF_COUNT:    rdata = count;
         OFF_PRESCALE: rdata = 32'(prescale_q);
         OFF_STATUS:   rdata = {31'd0, expired};
         default:      rdata = '0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      ack_d   = 1'b0;
      err_d   = 1'b0;
      dat_d   = '0;
      unique case (state_q)
         BUS_IDLE: begin
            if (wb.wb_cyc && wb.wb_stb) begin
               state_d = BUS_ACK;
               if (mapped) begin
                  ack_d = 1'b1;
                  if (!wb.wb_we) dat_d = rdata;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         BUS_ACK: state_d = BUS_IDLE;
         default: state_d = BUS_IDLE;
      endcase
   end

   assign irq_d = expired & ctrl_q[CTRL_IRQ_EN];

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q    <= BUS_IDLE;
         ack_q      <= 1'b0;
         err_q      <= 1'b0;
         dat_q      <= '0;
         irq_q      <= 1'b0;
         ctrl_q     <= '0;
         load_q     <= RESET_LOAD;
         prescale_q <= '0;
      end else begin
         state_q    <= state_d;
         ack_q      <= ack_d;
         err_q      <= err_d;
         dat_q      <= dat_d;
         irq_q      <= irq_d;
         ctrl_q     <= ctrl_d;
         load_q     <= load_d;
         prescale_q <= prescale_d;
      end
   end

   assign wb.wb_ack   = ack_q;
   assign wb.wb_err   = err_q;
   assign wb.wb_rty   = 1'b0;
   assign wb.wb_dat_r = dat_q;
   assign irq_o       = irq_q;

endmodule

// File: tb/tb_wb_timer_slave.sv
// Directed + randomized bench for wb_timer_slave.
// Expected timer values come from tick arithmetic, not a cycle model.
module tb_wb_timer_slave;

   localparam int          PW = 16;
   localparam logic [31:0] RL = 32'hCAFE_0000;

   localparam logic [31:0] A_CTRL   = 32'h00;
   localparam logic [31:0] A_LOAD   = 32'h04;
   localparam logic [31:0] A_COUNT  = 32'h08;
   localparam logic [31:0] A_PS     = 32'h0C;
   localparam logic [31:0] A_STATUS = 32'h10;

   logic clk = 1'b0;
   logic rst;
   logic irq;

   always #5 clk = ~clk;

   wb_timer_slave_if bus ();

   wb_timer_slave #(
      .PRESCALE_W (PW),
      .RESET_LOAD (RL)
   ) dut (
      .wb_clk_i (clk),
      .wb_rst_i (rst),
      .wb       (bus),
      .irq_o    (irq)
   );

   int n_chk  = 0;
   int n_fail = 0;
   int edge_n = 0;
   int last_at;

   always @(posedge clk) edge_n <= edge_n + 1;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic xfer(input  logic [31:0] a,
                       input  logic [31:0] d,
                       input  logic [3:0]  s,
                       input  logic        we,
                       output logic [31:0] rd,
                       output logic        ak,
                       output logic        er);
      @(negedge clk);
      bus.wb_adr   = a;
      bus.wb_dat_w = d;
      bus.wb_sel   = s;
      bus.wb_we    = we;
      bus.wb_cyc   = 1'b1;
      bus.wb_stb   = 1'b1;
      @(posedge clk);
      #1;
      rd      = bus.wb_dat_r;
      ak      = bus.wb_ack;
      er      = bus.wb_err;
      last_at = edge_n;
      bus.wb_cyc = 1'b0;
      bus.wb_stb = 1'b0;
      bus.wb_we  = 1'b0;
      @(posedge clk);
      #1;
      chk("ack_one_cycle", {30'd0, bus.wb_ack, bus.wb_err}, 32'd0);
   endtask

   task automatic wr(input logic [31:0] a,
                     input logic [31:0] d,
                     input logic [3:0]  s);
      logic [31:0] rd;
      logic ak, er;
      xfer(a, d, s, 1'b1, rd, ak, er);
      chk("wr_ack", {30'd0, ak, er}, 32'd2);
   endtask

   task automatic rd_val(input  logic [31:0] a,
                         output logic [31:0] v);
      logic ak, er;
      xfer(a, 32'd0, 4'hF, 1'b0, v, ak, er);
      chk("rd_ack", {30'd0, ak, er}, 32'd2);
   endtask

   task automatic rd_chk(input string tag,
                         input logic [31:0] a,
                         input logic [31:0] exp);
      logic [31:0] v;
      rd_val(a, v);
      chk(tag, v, exp);
   endtask

   function automatic logic [31:0] sel_mask(input logic [3:0] s);
      return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
   endfunction

   // Ticks land every p+1 cycles after the enabling edge n; a read at
   // edge m sees ticks on edges up to m-1.
   function automatic int ticks(input int m, input int n, input int p);
      return (m - 1 - n) / (p + 1);
   endfunction

   // Count after k ticks: c down to 0, then reload l and cycle l..0.
   function automatic logic [31:0] exp_count(input int k, input int c,
                                             input int l);
      if (k <= c) return 32'(c - k);
      return 32'(l - ((k - c - 1) % (l + 1)));
   endfunction

   initial begin
      logic [31:0] v, load_exp, ps_model, d;
      logic [3:0]  s;
      logic        ak, er;
      int n, m, k, p, c, l;

      rst          = 1'b1;
      bus.wb_adr   = '0;
      bus.wb_dat_w = '0;
      bus.wb_sel   = '0;
      bus.wb_cyc   = 1'b0;
      bus.wb_stb   = 1'b0;
      bus.wb_we    = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ack", {31'd0, bus.wb_ack}, 32'd0);
      chk("rst_err", {31'd0, bus.wb_err}, 32'd0);
      chk("rst_rty", {31'd0, bus.wb_rty}, 32'd0);
      chk("rst_dat", bus.wb_dat_r, 32'd0);
      chk("rst_irq", {31'd0, irq}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      rd_chk("rst_ctrl",   A_CTRL,   32'd0);
      rd_chk("rst_load",   A_LOAD,   RL);
      rd_chk("rst_count",  A_COUNT,  32'd0);
      rd_chk("rst_ps",     A_PS,     32'd0);
      rd_chk("rst_status", A_STATUS, 32'd0);

      // Byte-lane write, alias address, unmapped access, empty sel.
      wr(A_LOAD, 32'h1234_5678, 4'b0101);
      load_exp = (RL & ~sel_mask(4'b0101))
                 | (32'h1234_5678 & sel_mask(4'b0101));
      rd_chk("load_sel0101", A_LOAD, load_exp);
      rd_chk("load_alias", 32'h0000_0027, load_exp);
      xfer(32'h18, 32'd0, 4'hF, 1'b0, v, ak, er);
      chk("unmapped_rd_term", {30'd0, ak, er}, 32'd1);
      chk("unmapped_rd_dat", v, 32'd0);
      xfer(32'h1C, 32'hFFFF_FFFF, 4'hF, 1'b1, v, ak, er);
      chk("unmapped_wr_term", {30'd0, ak, er}, 32'd1);
      rd_chk("unmapped_no_load", A_LOAD, load_exp);
      wr(A_CTRL, 32'hFF, 4'b0000);
      rd_chk("sel0_ctrl", A_CTRL, 32'd0);

      // Auto-reload with prescale 3 and irq timing.
      p = 3; c = 2; l = 5;
      wr(A_PS, 32'(p), 4'hF);
      wr(A_LOAD, 32'(l), 4'hF);
      wr(A_COUNT, 32'(c), 4'hF);
      wr(A_CTRL, 32'h7, 4'hF);
      n = last_at;
      repeat (14) begin
         @(posedge clk);
         #1;
         chk("irq_timing", {31'd0, irq},
             {31'd0, edge_n >= n + (c + 1) * (p + 1) + 1});
      end
      for (int i = 0; i < 3; i++) begin
         rd_val(A_COUNT, v);
         k = ticks(last_at, n, p);
         chk("auto_count", v, exp_count(k, c, l));
         rd_val(A_STATUS, v);
         k = ticks(last_at, n, p);
         chk("auto_status", v, {31'd0, k >= c + 1});
      end
      wr(A_CTRL, 32'h0, 4'hF);
      wr(A_STATUS, 32'h1, 4'b1110);
      rd_chk("w1c_needs_sel0", A_STATUS, 32'd1);
      wr(A_STATUS, 32'h1, 4'b0001);
      rd_chk("w1c_clear", A_STATUS, 32'd0);
      chk("irq_after_clear", {31'd0, irq}, 32'd0);

      // One-shot expiry.
      wr(A_PS, 32'd0, 4'hF);
      wr(A_COUNT, 32'd1, 4'hF);
      wr(A_CTRL, 32'h1, 4'hF);
      repeat (2) @(posedge clk);
      rd_chk("oneshot_ctrl",   A_CTRL,   32'd0);
      rd_chk("oneshot_count",  A_COUNT,  32'd0);
      rd_chk("oneshot_status", A_STATUS, 32'd1);
      repeat (3) begin
         @(posedge clk);
         #1;
         chk("oneshot_no_irq", {31'd0, irq}, 32'd0);
      end
      wr(A_STATUS, 32'h1, 4'b0001);

      // W1C on the expiry edge, then COUNT write on a tick edge.
      wr(A_COUNT, 32'd1, 4'hF);
      wr(A_CTRL, 32'h3, 4'hF);
      n = last_at;
      wr(A_STATUS, 32'h1, 4'b0001);
      chk("w1c_on_expiry_edge", 32'(last_at - n), 32'd2);
      rd_chk("set_beats_clear", A_STATUS, 32'd1);
      wr(A_COUNT, 32'h1000, 4'hF);
      n = last_at;
      rd_val(A_COUNT, v);
      chk("count_write_wins", v, 32'h1000 - 32'(last_at - 1 - n));
      wr(A_CTRL, 32'h0, 4'hF);
      wr(A_STATUS, 32'h1, 4'b0001);

      // Randomized PRESCALE byte merge and timer runs vs tick model.
      ps_model = 32'd0;
      for (int it = 0; it < 3; it++) begin
         d = $urandom;
         s = 4'($urandom_range(0, 15));
         ps_model = ((ps_model & ~sel_mask(s)) | (d & sel_mask(s)))
                    & 32'h0000_FFFF;
         wr(A_PS, d, s);
         rd_chk("ps_merge", A_PS, ps_model);
         p = $urandom_range(0, 3);
         c = $urandom_range(0, 12);
         l = $urandom_range(0, 6);
         wr(A_PS, 32'(p), 4'hF);
         ps_model = 32'(p);
         wr(A_LOAD, 32'(l), 4'hF);
         wr(A_COUNT, 32'(c), 4'hF);
         wr(A_CTRL, 32'h3, 4'hF);
         n = last_at;
         for (int j = 0; j < 4; j++) begin
            repeat ($urandom_range(0, 5)) @(posedge clk);
            rd_val(A_COUNT, v);
            m = last_at;
            k = ticks(m, n, p);
            chk("rand_count", v, exp_count(k, c, l));
            rd_val(A_STATUS, v);
            k = ticks(last_at, n, p);
            chk("rand_status", v, {31'd0, k >= c + 1});
         end
         wr(A_CTRL, 32'h0, 4'hF);
         wr(A_STATUS, 32'h1, 4'b0001);
      end

      // Reset asserted while ack is high.
      wr(A_PS, 32'd9, 4'hF);
      wr(A_LOAD, 32'h55, 4'hF);
      wr(A_COUNT, 32'h77, 4'hF);
      wr(A_CTRL, 32'h7, 4'hF);
      @(negedge clk);
      bus.wb_adr = A_LOAD;
      bus.wb_we  = 1'b0;
      bus.wb_sel = 4'hF;
      bus.wb_cyc = 1'b1;
      bus.wb_stb = 1'b1;
      @(posedge clk);
      #1;
      chk("pre_rst_ack", {31'd0, bus.wb_ack}, 32'd1);
      rst        = 1'b1;
      bus.wb_cyc = 1'b0;
      bus.wb_stb = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_mid_ack", {31'd0, bus.wb_ack}, 32'd0);
      chk("rst_mid_dat", bus.wb_dat_r, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      rd_chk("rst2_ctrl",   A_CTRL,   32'd0);
      rd_chk("rst2_load",   A_LOAD,   RL);
      rd_chk("rst2_count",  A_COUNT,  32'd0);
      rd_chk("rst2_ps",     A_PS,     32'd0);
      rd_chk("rst2_status", A_STATUS, 32'd0);
      chk("rst2_irq", {31'd0, irq}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
